dice_roller_n: RTL and testbench



---
 rtl/dice_pkg.sv | 39 +++
 rtl/dice_die.sv | 52 +++++
 rtl/dice_roller_n.sv | 168 ++++++++++++++++
 tb/tb_dice_roller_n.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// ---------------------------------------------------------------------------
// dice_pkg
//   Shared definitions for the multi-die roller.
//   - state_t     : roller FSM states (IDLE=0, ROLL=1, SETTLE=2, SHOW=3)
//   - VAL_W       : width of one die value nibble (4)
//   - GRID_W      : width of one 3x3 pip grid (9)
//   - pip_pattern : die value -> pip grid, bit r*3+c lights row r, column c
// ---------------------------------------------------------------------------
package dice_pkg;

  localparam int VAL_W  = 4;
  localparam int GRID_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  // Grid layout:  0 1 2 / 3 4 5 / 6 7 8  (4 is the centre pip)
  function automatic logic [GRID_W-1:0] pip_pattern(input logic [VAL_W-1:0] value);
    logic [GRID_W-1:0] pips;
    case (value)
      4'd1:    pips = 9'h010;
      4'd2:    pips = 9'h101;
      4'd3:    pips = 9'h111;
      4'd4:    pips = 9'h145;
      4'd5:    pips = 9'h155;
      4'd6:    pips = 9'h16D;
      4'd7:    pips = 9'h17D;
      4'd8:    pips = 9'h1EF;
      4'd9:    pips = 9'h1FF;
      default: pips = 9'h000;
    endcase
    return pips;
  endfunction

endpackage

// File: rtl/dice_die.sv
// ---------------------------------------------------------------------------
// dice_die
//   One die of the odometer: a counter running 1..FACES that wraps back to 1
//   and reports a carry on the wrap.
//   Ports:
//     clk        : system clock, rising edge
//     reset      : synchronous, active-high; value returns to 1
//     step       : advance request arriving from the die below (or the FSM)
//     hold       : die is frozen; step is ignored and no carry is produced
//     value      : registered die value, 1..FACES
//     value_next : value the die takes on the next edge (feeds LED/SUM regs)
//     carry      : this die wraps FACES -> 1 on the next edge
// ---------------------------------------------------------------------------
module dice_die
  import dice_pkg::*;
#(
  parameter int FACES = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             hold,
  output logic [VAL_W-1:0] value,
  output logic [VAL_W-1:0] value_next,
  output logic             carry
);

  localparam logic [VAL_W-1:0] TOP_VALUE = VAL_W'(FACES);

  // NOTE: every output of a combinational block gets a default on entry,
  // otherwise the paths that skip an assignment infer a latch.
  always_comb begin
    value_next = value;
    carry      = 1'b0;
    if (step && !hold) begin
      if (value == TOP_VALUE) begin
        value_next = 4'd1;
        carry      = 1'b1;
      end else begin
        value_next = value + 4'd1;
      end
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) value <= 4'd1;
    else       value <= value_next;
  end

endmodule

// File: rtl/dice_roller_n.sv
// ---------------------------------------------------------------------------
// dice_roller_n
//   NUM_DICE dice with FACES faces each. While START is held the dice spin as
//   an odometer (one advance per clock). When START drops the dice settle
//   with SETTLE_STEPS advances spaced 1,2,4,... cycles apart, then freeze in
//   SHOW and DONE pulses for one cycle.
//   Optional macro DICE_HOLD_EN adds the HOLD input: held dice keep their
//   value and the advance/carry chain skips over them.
//   Ports:
//     CLK     : system clock, rising edge
//     RST     : synchronous, active-high reset
//     START   : roll request, already synchronised, level-sensitive
//     HOLD    : per-die freeze (only with DICE_HOLD_EN)
//     VAL     : packed die values, die i in [4i+3:4i]
//     LED     : packed pip grids, die i in [9i+8:9i]
//     SUM     : sum of all die values
//     ROLLING : high in ROLL and SETTLE
//     DONE    : one-cycle pulse on entry to SHOW
// ---------------------------------------------------------------------------
module dice_roller_n
  import dice_pkg::*;
#(
  parameter int NUM_DICE     = 2,
  parameter int FACES        = 6,
  parameter int SETTLE_STEPS = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
`ifdef DICE_HOLD_EN
  input  logic [NUM_DICE-1:0]        HOLD,
`endif
  output logic [VAL_W*NUM_DICE-1:0]  VAL,
  output logic [GRID_W*NUM_DICE-1:0] LED,
  output logic [5:0]                 SUM,
  output logic                       ROLLING,
  output logic                       DONE
);

  state_t                     state;
  logic [7:0]                 cnt;
  logic [3:0]                 k;
  logic [7:0]                 settle_limit;
  logic                       settle_hit;
  logic                       settle_last;
  logic                       advance;
  logic [NUM_DICE-1:0]        hold;
  logic [NUM_DICE:0]          inc;
  logic [VAL_W*NUM_DICE-1:0]  val_next;
  logic [GRID_W*NUM_DICE-1:0] led_next;
  logic [5:0]                 sum_next;
  logic                       carry_unused;

`ifdef DICE_HOLD_EN
  assign hold = HOLD;
`else
  assign hold = '0;
`endif

  // SETTLE advances when cnt reaches 2^k - 1, doubling the gap each time.
  assign settle_limit = (8'd1 << k) - 8'd1;
  assign settle_hit   = (cnt == settle_limit);
  assign settle_last  = (k == 4'(SETTLE_STEPS - 1));

  // A restart request in SETTLE pre-empts the pending settle advance.
  assign advance = (state == ROLL) ||
                   ((state == SETTLE) && !START && settle_hit);

  // Odometer chain: a held die passes the incoming step straight through to
  // the next die, so the step lands on the lowest non-held die above.
  assign inc[0] = advance;

  for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
    logic carry;

    dice_die #(
      .FACES(FACES)
    ) u_die (
      .clk       (CLK),
      .reset     (RST),
      .step      (inc[i]),
      .hold      (hold[i]),
      .value     (VAL[i*VAL_W +: VAL_W]),
      .value_next(val_next[i*VAL_W +: VAL_W]),
      .carry     (carry)
    );

    assign inc[i+1] = hold[i] ? inc[i] : carry;
  end

  // Carry out of the top die is intentionally discarded.
  assign carry_unused = inc[NUM_DICE];

  // LED and SUM are built from the next die values so that, once
  // registered, they line up with VAL in the same cycle.
  always_comb begin
    led_next = '0;
    sum_next = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      led_next[i*GRID_W +: GRID_W] = pip_pattern(val_next[i*VAL_W +: VAL_W]);
      sum_next = sum_next + 6'(val_next[i*VAL_W +: VAL_W]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      LED <= {NUM_DICE{9'h010}};
      SUM <= 6'(NUM_DICE);
    end else begin
      LED <= led_next;
      SUM <= sum_next;
    end
  end

  // Roller FSM with registered ROLLING/DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      ROLLING <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state   <= ROLL;
            ROLLING <= 1'b1;
          end
        end
        ROLL: begin
          if (!START) begin
            state <= SETTLE;
            cnt   <= '0;
            k     <= '0;
          end
        end
        SETTLE: begin
          if (START) begin
            state <= ROLL;
          end else if (settle_hit) begin
            cnt <= '0;
            k   <= k + 4'd1;
            if (settle_last) begin
              state   <= SHOW;
              ROLLING <= 1'b0;
              DONE    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHOW: begin
          if (START) begin
            state   <= ROLL;
            ROLLING <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ROLLING <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller_n.sv
// ---------------------------------------------------------------------------
// tb_dice_roller_n
//   Self-checking bench for dice_roller_n (NUM_DICE=2, FACES=6,
//   SETTLE_STEPS=3). A behavioural model tracks the dice as an array of
//   integers and the roller as a mode plus elapsed settle time; every cycle
//   all outputs are compared against it, with directed scenarios followed by
//   a randomized START/RST (and HOLD when DICE_HOLD_EN is defined) run.
// ---------------------------------------------------------------------------
module tb_dice_roller_n;

  localparam int N  = 2;
  localparam int F  = 6;
  localparam int SS = 3;

  localparam int M_IDLE   = 0;
  localparam int M_ROLL   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_SHOW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  hold_m;
  logic [4*N-1:0] val;
  logic [9*N-1:0] led;
  logic [5:0]    sum;
  logic          rolling;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int dice [N];
  int mode;
  int settle_t;
  bit exp_done;

  always #5 clk = ~clk;

  dice_roller_n #(
    .NUM_DICE    (N),
    .FACES       (F),
    .SETTLE_STEPS(SS)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
`ifdef DICE_HOLD_EN
    .HOLD   (hold_m),
`endif
    .VAL    (val),
    .LED    (led),
    .SUM    (sum),
    .ROLLING(rolling),
    .DONE   (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] pips_of(input int v);
    logic [8:0] p;
    p = '0;
    if (v == 1 || v == 3 || v == 5 || v == 7 || v == 9) p[4] = 1'b1;
    if (v >= 2) begin p[0] = 1'b1; p[8] = 1'b1; end
    if (v >= 4) begin p[2] = 1'b1; p[6] = 1'b1; end
    if (v >= 6) begin p[3] = 1'b1; p[5] = 1'b1; end
    if (v >= 8) begin p[1] = 1'b1; p[7] = 1'b1; end
    return p;
  endfunction

  // One odometer advance: the lowest non-held die ticks, wraps carry upward
  // to the next non-held die; a carry beyond the top die is lost.
  task automatic model_advance();
    bit c;
    c = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (c && !hold_m[i]) begin
        dice[i] = dice[i] % F + 1;
        c = (dice[i] == 1);
      end
    end
  endtask

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < N; i++) dice[i] = 1;
      mode     = M_IDLE;
      settle_t = 0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      case (mode)
        M_IDLE: if (start) mode = M_ROLL;
        M_ROLL: begin
          model_advance();
          if (!start) begin
            mode     = M_SETTLE;
            settle_t = 0;
          end
        end
        M_SETTLE: begin
          if (start) mode = M_ROLL;
          else begin
            settle_t++;
            if (is_pow2(settle_t + 1)) model_advance();
            if (settle_t == (1 << SS) - 1) begin
              mode     = M_SHOW;
              exp_done = 1'b1;
            end
          end
        end
        default: if (start) mode = M_ROLL;
      endcase
    end
  endtask

  task automatic compare();
    logic [4*N-1:0] ev;
    logic [9*N-1:0] el;
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      ev[4*i +: 4] = 4'(dice[i]);
      el[9*i +: 9] = pips_of(dice[i]);
      s += dice[i];
    end
    check("val", 32'(val), 32'(ev));
    check("led", 32'(led), 32'(el));
    check("sum", 32'(sum), 32'(s));
    check("rolling", 32'(rolling), 32'(mode == M_ROLL || mode == M_SETTLE));
    check("done", 32'(done), 32'(exp_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    hold_m = '0;

    // Reset state
    ticks(2);
    check("rst_val", 32'(val), 32'h11);
    check("rst_led", 32'(led), {14'd0, 9'h010, 9'h010});
    check("rst_sum", 32'(sum), 32'd2);
    check("rst_rolling", 32'(rolling), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Roll 8 cycles, then full settle
    start = 1'b1;
    ticks(8);
    start = 1'b0;
    tick();
    check("fall_die0", 32'(val[3:0]), 32'd3);
    check("fall_die1", 32'(val[7:4]), 32'd2);
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("settle_done", 32'(done), 32'(j == 7));
    end
    check("show_val", 32'(val), 32'h26);
    check("show_sum", 32'(sum), 32'd8);
    check("show_led0", 32'(led[8:0]), 32'h16D);
    check("show_led1", 32'(led[17:9]), 32'h101);
    check("show_rolling", 32'(rolling), 32'd0);
    tick();
    check("done_pulse_end", 32'(done), 32'd0);

    // Wrap-around: 36 advances returns to 1,1 with the top carry dropped
    do_reset();
    start = 1'b1;
    ticks(36);
    start = 1'b0;
    tick();
    check("wrap_val", 32'(val), 32'h11);
    ticks(8);

    // Restart during SETTLE
    start = 1'b1;
    ticks(3);
    start = 1'b0;
    ticks(2);
    start = 1'b1;
    tick();
    check("restart_rolling", 32'(rolling), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    ticks(2);
    start = 1'b0;
    tick();
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("resettle_done", 32'(done), 32'(j == 7));
      check("resettle_rolling", 32'(rolling), 32'(j < 7));
    end

    // Reset mid-ROLL with START held
    start = 1'b1;
    ticks(4);
    rst = 1'b1;
    tick();
    check("midroll_rst_val", 32'(val), 32'h11);
    check("midroll_rst_rolling", 32'(rolling), 32'd0);
    rst = 1'b0;
    tick();
    check("midroll_reenter", 32'(rolling), 32'd1);
    check("midroll_noadv", 32'(val), 32'h11);
    tick();
    check("midroll_adv", 32'(val), 32'h12);
    start = 1'b0;
    ticks(9);

`ifdef DICE_HOLD_EN
    // Hold die0: advances go straight to die1
    do_reset();
    hold_m = 2'b01;
    start  = 1'b1;
    ticks(5);
    start = 1'b0;
    tick();
    check("hold_die0", 32'(val[3:0]), 32'd1);
    check("hold_die1", 32'(val[7:4]), 32'd6);
    ticks(8);
    // All held: timing runs, DONE pulses, values frozen
    hold_m = 2'b11;
    start  = 1'b1;
    ticks(4);
    start = 1'b0;
    tick();
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("allhold_done", 32'(done), 32'(j == 7));
    end
    check("allhold_val", 32'(val), 32'h31);
    hold_m = '0;
`endif

    // Randomized run against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) start = ~start;
`ifdef DICE_HOLD_EN
      if ($urandom_range(0, 31) == 0) hold_m = N'($urandom);
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
